alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor of the combinational 32-bit ALU used by the datapath.
- Adds a start/done handshake and registered flags (zero, carry, overflow).
- Provides a multi-cycle unsigned MOD operation via an iterative restoring-remainder unit.
- Sits in the EX stage; the control unit stalls on busy while MOD runs.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), width of the MOD iteration counter.

Ports:
- CLK  input  1  clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; operands and alu_ctr are sampled on the edge where start=1 and busy=0
- alu_src1  input  WIDTH  operand A
- alu_src2  input  WIDTH  operand B
- alu_ctr  input  3  operation select
- busy  output  1  high while an operation is in progress (IDLE excluded)
- done  output  1  one-cycle pulse when alu_result/flags are updated
- alu_result  output  WIDTH  registered result, held until the next completion
- zero_bit  output  1  registered; 1 iff the completed alu_result == 0
- carry_out  output  1  registered adder carry for ADD/SUB; 0 for other ops
- overflow  output  1  registered signed overflow for ADD/SUB; 0 for other ops

Behaviour:
- Reset (synchronous, takes effect on the edge where reset=1, overrides start):
  - State returns to IDLE.
  - busy, done, alu_result, zero_bit, carry_out and overflow all go to 0.
  - Any operation in flight is abandoned without producing done.
- Opcodes (alu_ctr):
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SLT (signed A<B, result 1/0 zero-extended), 101 NOR, 110 SUB (A-B as A+~B+1), 111 MOD (unsigned A mod B).
  - SUB and SLT use carry-in = 1 into the shared adder.
- States: IDLE, MOD_RUN, MOD_FIN.
- IDLE:
  - start=1 with a non-MOD op: compute combinationally, register result and flags on that edge, pulse done for the next cycle. Latency is 1 and busy stays 0.
  - start=1 with MOD and B != 0: load remainder=0, quotient shift register=A, counter=0. Go to MOD_RUN; busy=1 from the next cycle.
  - start=1 with MOD and B == 0: treat as 1-cycle completion with result=A, carry_out=0, overflow=0.
- MOD_RUN, one iteration per cycle:
  - Shift {rem, q} left by 1.
  - If the shifted rem >= B (unsigned, WIDTH+1-bit compare), set rem = rem - B.
  - Increment the counter. After the WIDTH-th iteration, go to MOD_FIN.
- MOD_FIN: register alu_result = rem and zero_bit, pulse done, clear busy, return to IDLE.
- Total MOD latency: done is high in the cycle after edge WIDTH+1, counted from the start edge.
- start while busy=1 is ignored: no queueing and the in-flight operands are unchanged.
- Operands may change freely after the sampling edge; they are held internally.
- done is never high for two consecutive cycles from a single request. Back-to-back 1-cycle ops (start held high) give done every cycle.
- alu_result, zero_bit, carry_out and overflow change only on a completing edge or on reset.
- Width rules:
  - All arithmetic wraps modulo 2^WIDTH.
  - carry_out = bit WIDTH of the (WIDTH+1)-bit sum.
  - overflow = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the post-inversion adder input.

Decomposition:
- Package alu_seq_pkg: 3-bit opcode constants (OP_AND .. OP_MOD) and state encoding constants (S_IDLE, S_MOD_RUN, S_MOD_FIN).
- Sub-module mod_iter:
  - Holds rem/q registers, the counter, and the shift-subtract step.
  - Ports: CLK, reset, load, A, B, step, rem, last.
- The top level keeps the FSM, the shared adder, the logic ops and the output registers.

Test Plan:
- WIDTH=32, reset held 2 cycles -> all outputs 0, busy=0; then start ADD 7+5 -> next cycle done=1, alu_result=12, zero_bit=0, carry_out=0.
- SUB 5-5 -> alu_result=0, zero_bit=1, carry_out=1. SUB 0x7FFFFFFF-0xFFFFFFFF -> alu_result=0x80000000, overflow=1.
- SLT 0xFFFFFFFF vs 1 -> alu_result=1. SLT 1 vs 0xFFFFFFFF -> 0. NOR 0,0 -> 0xFFFFFFFF.
- MOD 100 % 7 -> busy=1 for 33 cycles, done exactly 33 edges after start, alu_result=2. MOD 0xFFFFFFFF % 0x10 -> 0xF.
- MOD 55 % 0 -> done next cycle, alu_result=55, busy never 1. start ADD pulsed during a MOD run -> ignored, MOD result unaffected.
- Start MOD 100 % 7, assert reset at iteration 10 -> next cycle busy=0, done=0, alu_result=0, and no later done. A fresh ADD 1+1 then returns 2.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the registered ALU and its MOD unit.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MOD_RUN = 2'd1,
    S_MOD_FIN = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mod_iter.sv
// Iterative restoring-remainder unit: one shift-subtract step per enabled cycle.
module mod_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             step,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_hold;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH-1:0] diff_c;

  // Remainder stays below B, so the difference always fits in WIDTH bits.
  always_comb begin
    shifted_c = {rem, q[WIDTH-1]};
    diff_c    = shifted_c[WIDTH-1:0] - b_hold;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rem    <= '0;
      q      <= '0;
      b_hold <= '0;
      cnt    <= '0;
    end else if (load) begin
      rem    <= '0;
      q      <= A;
      b_hold <= B;
      cnt    <= '0;
    end else if (step) begin
      rem <= (shifted_c >= {1'b0, b_hold}) ? diff_c : shifted_c[WIDTH-1:0];
      q   <= {q[WIDTH-2:0], 1'b0};
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, registered flags and a multi-cycle MOD.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic [2:0]       alu_ctr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_bit,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned SUM_W = WIDTH + 1;

  state_t           state;
  logic             sub_c;
  logic             arith_c;
  logic             ovf_c;
  logic             mod_go_c;
  logic [WIDTH-1:0] b_in_c;
  logic [SUM_W-1:0] sum_c;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] mod_rem;
  logic             mod_last;

  // Shared adder; SUB and SLT invert B and inject carry-in.
  always_comb begin
    sub_c    = (alu_ctr == OP_SUB) || (alu_ctr == OP_SLT);
    arith_c  = (alu_ctr == OP_SUB) || (alu_ctr == OP_ADD);
    b_in_c   = sub_c ? ~alu_src2 : alu_src2;
    sum_c    = {1'b0, alu_src1} + {1'b0, b_in_c} + SUM_W'(sub_c);
    ovf_c    = (alu_src1[WIDTH-1] == b_in_c[WIDTH-1]) &&
               (sum_c[WIDTH-1] != alu_src1[WIDTH-1]);
    mod_go_c = (state == S_IDLE) && start && (alu_ctr == OP_MOD) &&
               (alu_src2 != '0);
    res_c    = '0;
    case (alu_ctr)
      OP_AND: res_c = alu_src1 & alu_src2;
      OP_OR:  res_c = alu_src1 | alu_src2;
      OP_ADD: res_c = sum_c[WIDTH-1:0];
      OP_XOR: res_c = alu_src1 ^ alu_src2;
      OP_SLT: res_c = WIDTH'(sum_c[WIDTH-1] ^ ovf_c);
      OP_NOR: res_c = ~(alu_src1 | alu_src2);
      OP_SUB: res_c = sum_c[WIDTH-1:0];
      OP_MOD: res_c = alu_src1;  // only reached when B == 0
    endcase
  end

  mod_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mod_iter (
    .CLK   (CLK),
    .reset (reset),
    .load  (mod_go_c),
    .A     (alu_src1),
    .B     (alu_src2),
    .step  (state == S_MOD_RUN),
    .rem   (mod_rem),
    .last  (mod_last)
  );

  // Control FSM and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_result <= '0;
      zero_bit   <= 1'b0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mod_go_c) begin
            state <= S_MOD_RUN;
            busy  <= 1'b1;
          end else if (start) begin
            alu_result <= res_c;
            zero_bit   <= (res_c == '0);
            carry_out  <= arith_c & sum_c[WIDTH];
            overflow   <= arith_c & ovf_c;
            done       <= 1'b1;
          end
        end
        S_MOD_RUN: begin
          if (mod_last) state <= S_MOD_FIN;
        end
        S_MOD_FIN: begin
          alu_result <= mod_rem;
          zero_bit   <= (mod_rem == '0);
          carry_out  <= 1'b0;
          overflow   <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] alu_src1;
  logic [W-1:0] alu_src2;
  logic [2:0]   alu_ctr;
  logic         busy;
  logic         done;
  logic [W-1:0] alu_result;
  logic         zero_bit;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctr    (alu_ctr),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .zero_bit   (zero_bit),
    .carry_out  (carry_out),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  // Present one request for one edge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    alu_ctr  = op;
    alu_src1 = a;
    alu_src2 = b;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
    alu_src1 = $urandom;
    alu_src2 = $urandom;
  endtask

  // Run a MOD and observe handshake; k counts edges after the start edge.
  task automatic run_mod(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse,
                         output int done_k, output int busy_cnt, output int done_cnt);
    done_k = -1; busy_cnt = 0; done_cnt = 0;
    @(negedge CLK);
    alu_ctr = 3'b111; alu_src1 = a; alu_src2 = b; start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      start = pulse && (k == 5);
      if (k == 0 || k == 5) begin
        alu_ctr  = pulse ? 3'b010 : 3'b111;
        alu_src1 = $urandom;
        alu_src2 = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; alu_ctr = '0; alu_src1 = '0; alu_src2 = '0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({busy, done, zero_bit, carry_out, overflow} !== 5'b0 || alu_result !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b res=%h z=%b c=%b v=%b, required all 0",
               busy, done, alu_result, zero_bit, carry_out, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_add;
    issue(3'b010, 32'd7, 32'd5);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'd12 || zero_bit !== 1'b0 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL add_7_5: done=%b res=%0d z=%b c=%b, required 1/12/0/0",
               done, alu_result, zero_bit, carry_out);
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b0 || alu_result !== 32'd12) begin
      n_fail++;
      $display("FAIL add_hold: done=%b res=%0d, required done=0 res=12", done, alu_result);
    end
  endtask

  task automatic test_sub;
    issue(3'b110, 32'd5, 32'd5);
    n_checks++;
    if (alu_result !== 32'd0 || zero_bit !== 1'b1 || carry_out !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_5_5: res=%h z=%b c=%b v=%b, required 0/1/1/0",
               alu_result, zero_bit, carry_out, overflow);
    end
    issue(3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if (alu_result !== 32'h8000_0000 || overflow !== 1'b1 || carry_out !== 1'b0 || zero_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_ovf: res=%h v=%b c=%b z=%b, required 80000000/1/0/0",
               alu_result, overflow, carry_out, zero_bit);
    end
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    n_checks++;
    if (alu_result !== 32'd0 || carry_out !== 1'b1 || overflow !== 1'b0 || zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: res=%h c=%b v=%b z=%b, required 0/1/0/1",
               alu_result, carry_out, overflow, zero_bit);
    end
  endtask

  task automatic test_logic;
    issue(3'b100, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if (alu_result !== 32'd1 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_neg_pos: res=%h c=%b v=%b, required 1/0/0", alu_result, carry_out, overflow);
    end
    issue(3'b100, 32'd1, 32'hFFFF_FFFF);
    n_checks++;
    if (alu_result !== 32'd0 || zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL slt_pos_neg: res=%h z=%b, required 0/1", alu_result, zero_bit);
    end
    issue(3'b101, 32'd0, 32'd0);
    n_checks++;
    if (alu_result !== 32'hFFFF_FFFF || zero_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL nor_0_0: res=%h z=%b, required ffffffff/0", alu_result, zero_bit);
    end
    issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    n_checks++;
    if (alu_result !== 32'h00F0_1200) begin
      n_fail++;
      $display("FAIL and: res=%h, required 00f01200", alu_result);
    end
    issue(3'b001, 32'hF000_0001, 32'h0000_0F00);
    n_checks++;
    if (alu_result !== 32'hF000_0F01) begin
      n_fail++;
      $display("FAIL or: res=%h, required f0000f01", alu_result);
    end
    issue(3'b011, 32'hAAAA_5555, 32'hFFFF_0000);
    n_checks++;
    if (alu_result !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL xor: res=%h, required 55555555", alu_result);
    end
  endtask

  task automatic test_mod;
    int dk, bc, dc;
    run_mod(32'd100, 32'd7, 1'b0, dk, bc, dc);
    n_checks++;
    if (dk !== 33 || bc !== 33 || dc !== 1 || alu_result !== 32'd2 || zero_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_100_7: done_edge=%0d busy_cycles=%0d dones=%0d res=%0d z=%b, required 33/33/1/2/0",
               dk, bc, dc, alu_result, zero_bit);
    end
    run_mod(32'hFFFF_FFFF, 32'h10, 1'b1, dk, bc, dc);
    n_checks++;
    if (dk !== 33 || dc !== 1 || alu_result !== 32'hF || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_ffffffff_10_with_pulse: done_edge=%0d dones=%0d res=%h c=%b v=%b, required 33/1/f/0/0",
               dk, dc, alu_result, carry_out, overflow);
    end
    run_mod(32'd55, 32'd0, 1'b0, dk, bc, dc);
    n_checks++;
    if (dk !== 0 || bc !== 0 || dc !== 1 || alu_result !== 32'd55) begin
      n_fail++;
      $display("FAIL mod_by_zero: done_edge=%0d busy_cycles=%0d dones=%0d res=%0d, required 0/0/1/55",
               dk, bc, dc, alu_result);
    end
    run_mod(32'd49, 32'd7, 1'b0, dk, bc, dc);
    n_checks++;
    if (dk !== 33 || alu_result !== 32'd0 || zero_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_49_7: done_edge=%0d res=%0d z=%b, required 33/0/1", dk, alu_result, zero_bit);
    end
  endtask

  task automatic test_reset_mid_mod;
    int dc;
    issue(3'b010, 32'd40, 32'd2);  // leave a nonzero result behind
    @(negedge CLK);
    alu_ctr = 3'b111; alu_src1 = 32'd100; alu_src2 = 32'd7; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mod: busy=%b done=%b res=%h, required 0/0/0", busy, done, alu_result);
    end
    dc = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done || busy) dc++;
    end
    n_checks++;
    if (dc !== 0) begin
      n_fail++;
      $display("FAIL reset_abandon: late done/busy cycles=%0d, required 0", dc);
    end
    issue(3'b010, 32'd1, 32'd1);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'd2) begin
      n_fail++;
      $display("FAIL add_after_reset: done=%b res=%0d, required 1/2", done, alu_result);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    alu_ctr = 3'b010; alu_src1 = 32'd1; alu_src2 = 32'd2; start = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_1: done=%b res=%h, required 1/3", done, alu_result);
    end
    alu_ctr = 3'b011; alu_src1 = 32'hF0; alu_src2 = 32'hFF;
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'h0F) begin
      n_fail++;
      $display("FAIL b2b_2: done=%b res=%h, required 1/f", done, alu_result);
    end
    alu_ctr = 3'b110; alu_src1 = 32'd3; alu_src2 = 32'd4;
    @(negedge CLK);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'hFFFF_FFFF || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_3: done=%b res=%h c=%b v=%b, required 1/ffffffff/0/0",
               done, alu_result, carry_out, overflow);
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b0 || alu_result !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL b2b_end: done=%b res=%h, required 0/ffffffff", done, alu_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mod();
    test_reset_mid_mod();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
